prng_stream_adapter: RTL and testbench

//  Downstream consumer of nlfsr_128. Samples the free-running 128-bit prng_output on request and

---
 rtl/prng_pkg.sv | 17 +
 rtl/prng_sample_fifo.sv | 73 +++++++
 rtl/prng_stream_adapter.sv | 130 +++++++++++++
 tb/tb_prng_stream_adapter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared widths and helpers for the PRNG stream adapter slice.
package prng_pkg;

  localparam int unsigned PRNG_DATA_W = 128;
  localparam int unsigned PRNG_OUT_W  = 32;

  function automatic int unsigned words_per_sample(input int unsigned data_w,
                                                   input int unsigned out_w);
    return data_w / out_w;
  endfunction

  // Index counter width; kept at least 1 bit so a single-word sample still elaborates.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/prng_sample_fifo.sv
// DEPTH x DATA_W synchronous sample FIFO with async reset; push into a full FIFO
// is accepted only when a pop happens on the same edge.
module prng_sample_fifo
  import prng_pkg::*;
#(
  parameter int unsigned DATA_W = PRNG_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset: clearing the pointers and level already discards every entry.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/prng_stream_adapter.sv
// Samples prng_output into a FIFO and streams each sample LSB-word first on valid/ready.
// Optional repeat/zero health check is enabled by defining PRNG_HEALTH_EN.
module prng_stream_adapter
  import prng_pkg::*;
#(
  parameter int unsigned DATA_W = PRNG_DATA_W,
  parameter int unsigned OUT_W  = PRNG_OUT_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      prng_output,
  input  logic                   sample_en,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   health_fail
);

  localparam int unsigned WORDS = words_per_sample(DATA_W, OUT_W);
  localparam int unsigned IDX_W = idx_width(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  logic [DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              xfer;
  logic              pop;
  logic              push;
  logic              drop;
  logic              eligible;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  prng_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (prng_output),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && (idx_q == LAST_IDX);
  // A full FIFO still takes a sample when its head leaves on the same edge.
  assign push      = sample_en && eligible && (!fifo_full || pop);
  assign drop      = sample_en && eligible && fifo_full && !pop;

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = head[idx_q*OUT_W +: OUT_W];
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (xfer) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      idx_q      <= idx_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

`ifdef PRNG_HEALTH_EN
  logic [DATA_W-1:0] last_q, last_d;
  logic              health_q, health_d;
  logic              repeat_hit;

  // Rejected samples never reach the FIFO and are not counted as drops.
  assign repeat_hit = (prng_output == last_q) || (prng_output == '0);
  assign eligible   = !repeat_hit;

  always_comb begin
    last_d   = last_q;
    health_d = health_q;
    if (sample_en) begin
      if (repeat_hit) begin
        health_d = 1'b1;
      end else begin
        last_d = prng_output;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q   <= '0;
      health_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      health_q <= health_d;
    end
  end

  assign health_fail = health_q;
`else
  assign eligible    = 1'b1;
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_prng_stream_adapter.sv
// Randomized and directed bench for prng_stream_adapter against a queue-based reference model.
module tb_prng_stream_adapter;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WORDS  = DATA_W / OUT_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] prng_output;
  logic              sample_en;
  logic              out_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CNT_W-1:0]  drop_cnt;
  logic              health_fail;

  prng_stream_adapter #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .prng_output (prng_output),
    .sample_en   (sample_en),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample queue, word position in head sample, drop count, health state.
  logic [DATA_W-1:0] m_q[$];
  int unsigned       m_idx;
  int unsigned       m_drop;
  bit                m_hf;
  logic [DATA_W-1:0] m_last;
  logic [DATA_W-1:0] prev_data;

  task automatic model_reset();
    m_q.delete();
    m_idx  = 0;
    m_drop = 0;
    m_hf   = 1'b0;
    m_last = '0;
  endtask

  function automatic logic [DATA_W-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic compare_all();
    logic [DATA_W-1:0] head;
    logic [OUT_W-1:0]  exp_word;
    exp_word = '0;
    if (m_q.size() != 0) begin
      head     = m_q[0];
      exp_word = head[m_idx*OUT_W +: OUT_W];
    end
    check_eq("out_valid",   out_valid,   (m_q.size() != 0));
    check_eq("out_data",    out_data,    exp_word);
    check_eq("fifo_level",  fifo_level,  128'(m_q.size()));
    check_eq("drop_cnt",    drop_cnt,    128'(m_drop));
    check_eq("health_fail", health_fail, m_hf);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare on the falling edge.
  task automatic step(input bit en, input bit rdy, input logic [DATA_W-1:0] data);
    bit valid, pop, ok, room;
    sample_en   = en;
    out_ready   = rdy;
    prng_output = data;
    valid = (m_q.size() != 0);
    pop   = valid && rdy && (m_idx == WORDS - 1);
    room  = (m_q.size() < DEPTH) || pop;
    ok    = 1'b1;
`ifdef PRNG_HEALTH_EN
    if (en) begin
      if (data == m_last || data == '0) begin
        ok   = 1'b0;
        m_hf = 1'b1;
      end else begin
        m_last = data;
      end
    end
`endif
    if (pop) void'(m_q.pop_front());
    if (en && ok) begin
      if (room) m_q.push_back(data);
      else if (m_drop < (1 << CNT_W) - 1) m_drop++;
    end
    if (valid && rdy) m_idx = (m_idx == WORDS - 1) ? 0 : m_idx + 1;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    compare_all();
  endtask

  logic [DATA_W-1:0] kval;
  logic [DATA_W-1:0] first;
  logic [DATA_W-1:0] x;
  logic [OUT_W-1:0]  exp_words [WORDS];

  initial begin
    reset       = 1'b1;
    sample_en   = 1'b0;
    out_ready   = 1'b0;
    prng_output = '0;
    model_reset();

    // Reset held 3 cycles, then idle
    repeat (3) begin
      @(negedge clk);
      compare_all();
    end
    reset = 1'b0;
    repeat (10) step(1'b0, 1'b0, rnd128());

    // Single capture, four words LSB first on consecutive cycles
    kval = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    exp_words[0] = 32'h7654_3210;
    exp_words[1] = 32'hFEDC_BA98;
    exp_words[2] = 32'h89AB_CDEF;
    exp_words[3] = 32'h0123_4567;
    step(1'b1, 1'b1, kval);
    check_eq("t2_word0", out_data, exp_words[0]);
    for (int i = 1; i < WORDS; i++) begin
      step(1'b0, 1'b1, rnd128());
      check_eq("t2_word", out_data, exp_words[i]);
    end
    step(1'b0, 1'b1, rnd128());
    check_eq("t2_level_empty", fifo_level, 0);
    check_eq("t2_valid_low", out_valid, 1'b0);

    // Fill with sink stalled: two overflow drops, head stable on word 0
    first = rnd128();
    step(1'b1, 1'b0, first);
    for (int i = 1; i < 6; i++) begin
      step(1'b1, 1'b0, rnd128());
      check_eq("t3_hold", out_data, first[31:0]);
    end
    check_eq("t3_level", fifo_level, DEPTH);
    check_eq("t3_drop", drop_cnt, 2);

    // Full FIFO: capture on the pop edge is accepted
    repeat (WORDS - 1) step(1'b0, 1'b1, rnd128());
    check_eq("t4_lastword", out_data, first[127:96]);
    step(1'b1, 1'b1, rnd128());
    check_eq("t4_level", fifo_level, DEPTH);
    check_eq("t4_drop", drop_cnt, 2);

    // Async reset mid-sample at word index 2
    step(1'b0, 1'b1, rnd128());
    step(1'b0, 1'b1, rnd128());
    #2 reset = 1'b1;
    #1;
    check_eq("t5_valid", out_valid, 1'b0);
    check_eq("t5_level", fifo_level, 0);
    check_eq("t5_drop", drop_cnt, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    compare_all();
    step(1'b0, 1'b1, rnd128());
    x = rnd128();
    step(1'b1, 1'b1, x);
    check_eq("t5_word0", out_data, x[31:0]);

    // Randomized traffic, with repeated and zero samples mixed in
    prev_data = x;
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      if (sel < 8)       x = prev_data;
      else if (sel < 12) x = '0;
      else               x = rnd128();
      prev_data = x;
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45, x);
    end

`ifdef PRNG_HEALTH_EN
    // Repeated then zero sample trips the sticky alarm, only one entry written
    pulse_reset();
    x = rnd128() | 128'h1;
    step(1'b1, 1'b0, x);
    check_eq("t6_hf_first", health_fail, 1'b0);
    step(1'b1, 1'b0, x);
    check_eq("t6_hf_repeat", health_fail, 1'b1);
    step(1'b1, 1'b0, '0);
    check_eq("t6_level", fifo_level, 1);
    check_eq("t6_drop", drop_cnt, 0);
    check_eq("t6_hf_sticky", health_fail, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
